i2c_frame_slave: RTL and testbench

//  Parametrised, CLK-synchronous I2C slave that replaces the SCL-clocked receiver in the slave path.

---
 rtl/i2c_frame_slave.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_frame_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_slave.sv
// I2C slave clocked from the system clock: oversampled SCL/SDA, fixed-length write frames
// into a parallel word, and read transfers served from a snapshot of tx_data.
module i2c_frame_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         FRAME_BYTES = 4,
    parameter int         TX_BYTES    = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        RXW  = 8 * FRAME_BYTES,
    localparam int        TXW  = 8 * TX_BYTES,
    localparam int        MAXB = (FRAME_BYTES > TX_BYTES) ? FRAME_BYTES : TX_BYTES,
    localparam int        CW   = $clog2(MAXB + 1)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_oe,
    output logic [RXW-1:0] rx_data,
    output logic           rx_valid,
    output logic           rx_err,
    input  logic [TXW-1:0] tx_data,
    output logic           busy,
    output logic [2:0]     state_out,
    output logic [CW-1:0]  byte_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BYTES);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_BYTES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   rw;
    logic [RXW-1:0]         frame_buf;
    logic [TXW-1:0]         tx_snap;
    logic [7:0]             tx_byte;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    // Synchronisers reset to the idle-bus level so no edge is invented when reset releases
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;
    assign state_out = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            busy      <= 1'b0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rw        <= 1'b0;
            frame_buf <= '0;
            tx_snap   <= '0;
            tx_byte   <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            // START/STOP abort whatever is in flight; a short write frame is flagged here
            if (start_det || stop_det) begin
                state    <= start_det ? ADDR : IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                if (busy && !rw && byte_cnt != '0 && byte_cnt < FRAME_CNT)
                    rx_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shift_reg[7:1] == SLAVE_ADDR) begin
                                state  <= ADDR_ACK;
                                busy   <= 1'b1;
                                sda_oe <= 1'b1;
                                rw     <= shift_reg[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!rw) begin
                                state  <= RX;
                                sda_oe <= 1'b0;
                            end else begin
                                // First data bit goes out on the same edge that ends the ACK
                                state   <= TX;
                                tx_snap <= (tx_data << 8) | TXW'(8'hFF);
                                tx_byte <= {tx_data[TXW-2 -: 7], 1'b0};
                                sda_oe  <= ~tx_data[TXW-1];
                                bit_cnt <= 4'd1;
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state   <= RX_ACK;
                            bit_cnt <= '0;
                            sda_oe  <= (byte_cnt < FRAME_CNT);
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            state  <= RX;
                            sda_oe <= 1'b0;
                            if (byte_cnt < FRAME_CNT)
                                frame_buf <= (frame_buf << 8) | RXW'(shift_reg);
                            if (byte_cnt == LAST_CNT) begin
                                rx_data  <= (frame_buf << 8) | RXW'(shift_reg);
                                rx_valid <= 1'b1;
                            end
                            if (byte_cnt != CNT_MAX)
                                byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                    TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= TX_ACK;
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                sda_oe  <= ~tx_byte[7];
                                tx_byte <= {tx_byte[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        // Snapshot refills with 0xFF, so reads past TX_BYTES return idle bytes
                        if (scl_rise) begin
                            if (!sda_s) begin
                                state   <= TX;
                                tx_byte <= tx_snap[TXW-1 -: 8];
                                tx_snap <= (tx_snap << 8) | TXW'(8'hFF);
                                bit_cnt <= '0;
                                if (byte_cnt != CNT_MAX)
                                    byte_cnt <= byte_cnt + CW'(1);
                            end else begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_frame_slave.sv
// Bench for i2c_frame_slave: a bit-banged I2C master drives directed and random transfers;
// frame/error pulses are scoreboarded against a transaction-level model of the slave.
module tb_i2c_frame_slave;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int FB  = 4;
    localparam int TXB = 4;
    localparam int Q   = 6;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
    } sbItem_t;

    logic        CLK;
    logic        RST;
    logic        scl;
    logic        sdaDrv;
    logic        sda_oe;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [31:0] txWord;
    logic        busy;
    logic [2:0]  state_out;
    logic [2:0]  byte_cnt;
    wire         sdaLine = ~sdaDrv & ~sda_oe;

    int          nChecks;
    int          nErrors;
    logic        busySeen;
    logic        oeSeen;
    logic [31:0] lastFrame;
    logic [7:0]  wrBytes[8];
    sbItem_t     sbQ[$];
    logic [6:0]  rAddr;
    logic        rRw;
    logic        rStop;
    int          rN;
    logic        ackBit;

    i2c_frame_slave #(
        .SLAVE_ADDR(ADDR), .FRAME_BYTES(FB), .TX_BYTES(TXB), .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK), .RST(RST), .scl_in(scl), .sda_in(sdaLine), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .tx_data(txWord),
        .busy(busy), .state_out(state_out), .byte_cnt(byte_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(posedge CLK);
        #1;
    endtask

    task automatic busStart();
        sdaDrv = 1'b0; waitQ();
        scl = 1'b1;    waitQ();
        sdaDrv = 1'b1; waitQ();
        scl = 1'b0;    waitQ();
    endtask

    task automatic busStop();
        sdaDrv = 1'b1; waitQ();
        scl = 1'b1;    waitQ();
        sdaDrv = 1'b0; waitQ();
        waitQ();
    endtask

    task automatic sendBit(input logic b);
        sdaDrv = ~b; waitQ();
        scl = 1'b1;  waitQ();
        waitQ();
        scl = 1'b0;  waitQ();
    endtask

    task automatic readBit(output logic b);
        sdaDrv = 1'b0; waitQ();
        scl = 1'b1;    waitQ();
        b = sdaLine;   waitQ();
        scl = 1'b0;    waitQ();
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) sendBit(d[i]);
        readBit(b);
        ack = ~b;
    endtask

    task automatic readByte(output logic [7:0] d, input logic ackIt);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        sendBit(~ackIt);
    endtask

    // Every rx_valid/rx_err pulse must match the oldest outstanding expectation
    task automatic monitorLoop();
        sbItem_t e;
        forever begin
            @(negedge CLK);
            if (busy) busySeen = 1'b1;
            if (sda_oe) oeSeen = 1'b1;
            if (rx_valid || rx_err) begin
                checkOutput("valid_err_exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
                if (sbQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL sb_unexpected: got valid=%b err=%b, expected no pulse", rx_valid, rx_err);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_kind", {30'd0, rx_valid, rx_err}, {30'd0, e.kind});
                    checkOutput("sb_rx_data", rx_data, e.data);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [6:0] addr, input logic rw, input int n, input logic endStop);
        logic       match;
        logic       ack;
        logic [7:0] b;
        logic [7:0] expB;
        match = (addr == ADDR);
        if (match && !rw && n >= FB) begin
            lastFrame = {wrBytes[0], wrBytes[1], wrBytes[2], wrBytes[3]};
            sbQ.push_back('{2'b10, lastFrame});
        end else if (match && !rw && n > 0) begin
            sbQ.push_back('{2'b01, lastFrame});
        end
        busStart();
        busySeen = 1'b0;
        oeSeen   = 1'b0;
        sendByte({addr, rw}, ack);
        checkOutput("addr_ack", {31'd0, ack}, {31'd0, match});
        checkOutput("busy_after_addr", {31'd0, busy}, {31'd0, match});
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                sendByte(wrBytes[i], ack);
                checkOutput("write_ack", {31'd0, ack}, {31'd0, match && (i < FB)});
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                readByte(b, i != n - 1);
                expB = (match && i < TXB) ? txWord[31 - 8*i -: 8] : 8'hFF;
                checkOutput("read_byte", {24'd0, b}, {24'd0, expB});
            end
            if (match) begin
                checkOutput("busy_after_nack", {31'd0, busy}, 32'd0);
                checkOutput("state_ignore", {29'd0, state_out}, 32'd7);
            end
        end
        if (endStop) begin
            busStop();
            checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
        end
        if (!match) begin
            checkOutput("nomatch_sda_oe", {31'd0, oeSeen}, 32'd0);
            checkOutput("nomatch_busy", {31'd0, busySeen}, 32'd0);
        end
    endtask

    initial begin
        nChecks   = 0;
        nErrors   = 0;
        busySeen  = 1'b0;
        oeSeen    = 1'b0;
        lastFrame = 32'd0;
        txWord    = 32'd0;
        scl       = 1'b1;
        sdaDrv    = 1'b0;
        RST       = 1'b0;
        fork
            monitorLoop();
        join_none
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("reset_rx_data", rx_data, 32'd0);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_rx_err", {31'd0, rx_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_byte_cnt", {29'd0, byte_cnt}, 32'd0);
        checkOutput("reset_state", {29'd0, state_out}, 32'd0);
        RST = 1'b1;
        waitQ();

        wrBytes[0] = 8'h01; wrBytes[1] = 8'h0A; wrBytes[2] = 8'h0B; wrBytes[3] = 8'h0C;
        applyStimulus(ADDR, 1'b0, 4, 1'b1);
        wrBytes[0] = 8'h77; wrBytes[1] = 8'h88;
        applyStimulus(7'h43, 1'b0, 2, 1'b1);
        wrBytes[0] = 8'hAA; wrBytes[1] = 8'hBB;
        applyStimulus(ADDR, 1'b0, 2, 1'b1);
        wrBytes[0] = 8'h11; wrBytes[1] = 8'h22; wrBytes[2] = 8'h33; wrBytes[3] = 8'h44; wrBytes[4] = 8'h55;
        applyStimulus(ADDR, 1'b0, 5, 1'b1);
        txWord = 32'hDEADBEEF;
        applyStimulus(ADDR, 1'b1, 4, 1'b1);
        applyStimulus(ADDR, 1'b0, 0, 1'b1);

        // Reset while the slave is ACKing the second data byte; the aborted frame must vanish
        busStart();
        sendByte({ADDR, 1'b0}, ackBit);
        checkOutput("rst_addr_ack", {31'd0, ackBit}, 32'd1);
        sendByte(8'h55, ackBit);
        checkOutput("rst_byte_ack", {31'd0, ackBit}, 32'd1);
        for (int i = 7; i >= 0; i--) sendBit(1'b1);
        sdaDrv = 1'b0;
        waitQ();
        checkOutput("rst_ack_driven", {31'd0, sda_oe}, 32'd1);
        scl = 1'b1;
        waitQ();
        RST = 1'b0;
        #1;
        checkOutput("rst_sda_release", {31'd0, sda_oe}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_state", {29'd0, state_out}, 32'd0);
        waitQ();
        RST = 1'b1;
        waitQ();
        scl = 1'b0;
        waitQ();
        busStop();
        wrBytes[0] = 8'hC3; wrBytes[1] = 8'h5A; wrBytes[2] = 8'h96; wrBytes[3] = 8'h0F;
        applyStimulus(ADDR, 1'b0, 4, 1'b1);

        for (int t = 0; t < 14; t++) begin
            rAddr = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
            rRw   = 1'($urandom_range(0, 1));
            rN    = rRw ? $urandom_range(1, 6) : $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) wrBytes[i] = 8'($urandom);
            if (rRw) txWord = $urandom;
            rStop = (t == 13) ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus(rAddr, rRw, rN, rStop);
        end

        waitQ();
        checkOutput("sb_drained", sbQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
